// File: rtl/foo_bayer_stats.sv
// ---------------------------------------------------------------------------
// foo_bayer_stats
// Collects per-Bayer-channel frame statistics (sum and count of pedestal-
// subtracted pixels within the [pedestal, threshold] window). These feed gain
// calibration on the reader side of the foo correction path.
//
// Parameters
//   p_pix_bit   pixel width
//   p_acc_bit   per-channel sum width
//   p_cnt_bit   per-channel pixel-count width
//
// Ports
//   i_CLK                  clock, rising edge
//   i_RSTn                 asynchronous active-low reset
//   i_START                single-cycle frame-arm request (accepted in IDLE only)
//   i_ARR_TYPE             Bayer phase of pixel (0,0), captured on accepted start
//   i_VALID                pixel beat qualifier
//   i_SOL                  first pixel of a line (with i_VALID)
//   i_EOF                  last pixel of the frame (with i_VALID)
//   i_PIXEL                corrected pixel value
//   i_REG_FOO_PEDESTAL     black level
//   i_REG_FOO_THRES_BAYER  saturation threshold
//   i_RD_SEL               channel select for readout
//   o_BUSY                 frame in progress (ACCUM or FLUSH)
//   o_DONE                 single-cycle frame-complete pulse
//   o_SUM                  sum of selected channel
//   o_CNT                  count of selected channel
//   o_OVF                  sticky saturation flag for the frame
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for i_START; results held for readout
//   ST_ACCUM | accepting pixel beats until a valid EOF beat
//   ST_FLUSH | one cycle for the last beat to drain through the pipeline
// ---------------------------------------------------------------------------
module foo_bayer_stats #(
   parameter int p_pix_bit = 12,
   parameter int p_acc_bit = 32,
   parameter int p_cnt_bit = 24
) (
   input  logic                 i_CLK,
   input  logic                 i_RSTn,
   input  logic                 i_START,
   input  logic [1:0]           i_ARR_TYPE,
   input  logic                 i_VALID,
   input  logic                 i_SOL,
   input  logic                 i_EOF,
   input  logic [p_pix_bit-1:0] i_PIXEL,
   input  logic [p_pix_bit-1:0] i_REG_FOO_PEDESTAL,
   input  logic [p_pix_bit-1:0] i_REG_FOO_THRES_BAYER,
   input  logic [1:0]           i_RD_SEL,
   output logic                 o_BUSY,
   output logic                 o_DONE,
   output logic [p_acc_bit-1:0] o_SUM,
   output logic [p_cnt_bit-1:0] o_CNT,
   output logic                 o_OVF
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // Adder width wide enough to hold either operand plus a carry, so the
   // clip test works even when the sum is narrower than a pixel.
   localparam int lp_w = ((p_acc_bit > p_pix_bit) ? p_acc_bit : p_pix_bit) + 1;
   localparam logic [p_acc_bit-1:0] lp_acc_max = {p_acc_bit{1'b1}};

   logic [1:0]           state;
   logic [1:0]           arr;
   logic                 row;
   logic                 col;
   logic                 done;
   logic                 ovf;

   logic                 s1_q;
   logic [1:0]           s1_ch;
   logic [p_pix_bit-1:0] s1_val;

   logic [p_acc_bit-1:0] sum [4];
   logic [p_cnt_bit-1:0] cnt [4];

   logic                 start_ok;
   logic                 beat;
   logic                 row_cur;
   logic                 col_cur;
   logic [1:0]           ch_cur;
   logic                 in_range;

   logic [lp_w-1:0]      add_a;
   logic [lp_w-1:0]      add_b;
   logic [lp_w-1:0]      add_ext;
   logic [lp_w-1:0]      max_ext;
   logic                 sum_clip;
   logic                 cnt_full;
   logic [p_acc_bit-1:0] sum_nxt;
   logic [p_cnt_bit-1:0] cnt_nxt;

   assign start_ok = i_START && (state == ST_IDLE);
   assign beat     = i_VALID && (state == ST_ACCUM);

   // An SOL beat resets the column and toggles the row before the channel
   // is formed, so the same beat also lands in the new line.
   assign row_cur  = i_SOL ? ~row : row;
   assign col_cur  = i_SOL ? 1'b0 : col;
   assign ch_cur   = {row_cur ^ arr[1], col_cur ^ arr[0]};
   assign in_range = (i_PIXEL >= i_REG_FOO_PEDESTAL) && (i_PIXEL <= i_REG_FOO_THRES_BAYER);

   always_comb begin
      add_a = '0;
      add_b = '0;
      max_ext = '0;
      add_a[p_acc_bit-1:0]   = sum[s1_ch];
      add_b[p_pix_bit-1:0]   = s1_val;
      max_ext[p_acc_bit-1:0] = lp_acc_max;
      add_ext  = add_a + add_b;
      sum_clip = (add_ext > max_ext);
      sum_nxt  = sum_clip ? lp_acc_max : add_ext[p_acc_bit-1:0];
      cnt_full = &cnt[s1_ch];
      cnt_nxt  = cnt_full ? cnt[s1_ch] : cnt[s1_ch] + 1'b1;
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state <= ST_IDLE;
         arr   <= 2'd0;
         row   <= 1'b0;
         col   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= (state == ST_FLUSH);
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  state <= ST_ACCUM;
                  arr   <= i_ARR_TYPE;
                  row   <= 1'b1;
                  col   <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  row <= row_cur;
                  col <= ~col_cur;
                  if (i_EOF) begin
                     state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         s1_q   <= 1'b0;
         s1_ch  <= 2'd0;
         s1_val <= '0;
      end else begin
         s1_q <= beat && in_range;
         if (beat) begin
            s1_ch  <= ch_cur;
            s1_val <= i_PIXEL - i_REG_FOO_PEDESTAL;
         end
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         for (int i = 0; i < 4; i++) begin
            sum[i] <= '0;
            cnt[i] <= '0;
         end
         ovf <= 1'b0;
      end else if (start_ok) begin
         for (int i = 0; i < 4; i++) begin
            sum[i] <= '0;
            cnt[i] <= '0;
         end
         ovf <= 1'b0;
      end else if (s1_q) begin
         sum[s1_ch] <= sum_nxt;
         cnt[s1_ch] <= cnt_nxt;
         if (sum_clip || cnt_full) begin
            ovf <= 1'b1;
         end
      end
   end

   assign o_BUSY = (state == ST_ACCUM) || (state == ST_FLUSH);
   assign o_DONE = done;
   assign o_OVF  = ovf;
   assign o_SUM  = sum[i_RD_SEL];
   assign o_CNT  = cnt[i_RD_SEL];

endmodule
